// File: rtl/axis_video_pkg.sv
// -----------------------------------------------------------------------------
// axis_video_pkg
// Shared types for the AXI-Stream video framing stage.
//   state_t     : framer FSM states (IDLE / ACTIVE / DRAIN)
//   beat_tag_t  : video tags carried alongside every pixel through the skid
//                 buffer; the buffered payload layout is {tdata, beat_tag_t}
//   cnt_width() : counter width for a modulus, never less than 1 bit
// -----------------------------------------------------------------------------
package axis_video_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic tuser;  // start-of-frame
    logic tlast;  // end-of-line
  } beat_tag_t;

  localparam int unsigned TAG_WIDTH = 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry register slice with a registered upstream ready. The head register
// drives the output directly; the skid register catches the beat that is
// already in flight when the downstream stalls, so full throughput is kept
// while s_ready stays a pure flop output.
//   axi_clk, axi_rstn : clock, asynchronous active-low reset (empties buffer)
//   accept_en         : upstream may be admitted on the next cycle
//   s_data/s_valid/s_ready : upstream side
//   m_data/m_valid/m_ready : downstream side
//   level             : number of beats currently held (0..2)
// -----------------------------------------------------------------------------
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             axi_clk,
  input  logic             axi_rstn,
  input  logic             accept_en,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] head_data_reg, head_data_next;
  logic [WIDTH-1:0] skid_data_reg, skid_data_next;
  logic             head_valid_reg, head_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             ready_reg, ready_next;
  logic             push, pop;

  // ready_reg is only high with at most one entry held, so a push never
  // coincides with a full buffer.
  assign push = s_valid && ready_reg;
  assign pop  = head_valid_reg && m_ready;

  always_comb begin
    head_data_next  = head_data_reg;
    skid_data_next  = skid_data_reg;
    head_valid_next = head_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (pop) begin
      if (skid_valid_reg) begin
        head_data_next  = skid_data_reg;
        head_valid_next = 1'b1;
        skid_valid_next = push;
        if (push) skid_data_next = s_data;
      end else begin
        head_valid_next = push;
        if (push) head_data_next = s_data;
      end
    end else if (push) begin
      if (head_valid_reg) begin
        skid_valid_next = 1'b1;
        skid_data_next  = s_data;
      end else begin
        head_valid_next = 1'b1;
        head_data_next  = s_data;
      end
    end
    // Ready for the next cycle reflects the occupancy after this cycle.
    ready_next = accept_en && !(head_valid_next && skid_valid_next);
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      head_data_reg  <= '0;
      skid_data_reg  <= '0;
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      head_data_reg  <= head_data_next;
      skid_data_reg  <= skid_data_next;
      head_valid_reg <= head_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ready_next;
    end
  end

  assign s_ready = ready_reg;
  assign m_data  = head_data_reg;
  assign m_valid = head_valid_reg;
  assign level   = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: rtl/axis_line_framer.sv
// -----------------------------------------------------------------------------
// axis_line_framer
// Re-tags a burst-delimited pixel stream as a video stream: m_axis_tuser marks
// start-of-frame, m_axis_tlast marks end-of-line over H_ACTIVE x V_ACTIVE.
// Input burst framing (tlast every BURST_LEN beats) is checked; data always
// passes unchanged through a 2-entry skid buffer.
//   axi_clk, axi_rstn : clock, asynchronous active-low reset
//   enable, frame_sync: frame start gating and start-of-frame request
//   s_axis_*          : burst-delimited pixel input
//   m_axis_*          : tagged video output
//   busy              : FSM not in IDLE
//   frame_done        : pulse after the last pixel of a frame is emitted
//   burst_err         : pulse after a misplaced or missing input tlast
//   sync_err          : pulse after a frame_sync that aborted a frame
// -----------------------------------------------------------------------------
module axis_line_framer
  import axis_video_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  axi_clk,
  input  logic                  axi_rstn,
  input  logic                  enable,
  input  logic                  frame_sync,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  burst_err,
  output logic                  sync_err
);

  localparam int unsigned XW        = cnt_width(H_ACTIVE);
  localparam int unsigned YW        = cnt_width(V_ACTIVE);
  localparam int unsigned BW        = cnt_width(BURST_LEN);
  localparam int unsigned PAYLOAD_W = DATA_WIDTH + TAG_WIDTH;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST_LEN - 1);

  state_t                state_reg, state_next;
  logic [XW-1:0]         x_reg;
  logic [YW-1:0]         y_reg;
  logic [BW-1:0]         b_reg;
  logic                  frame_done_reg, burst_err_reg, sync_err_reg;

  beat_tag_t             in_tag, out_tag;
  logic [PAYLOAD_W-1:0]  in_payload, out_payload;
  logic [1:0]            level;
  logic                  accept, frame_last_beat, drain_done, restart;

  assign accept          = s_axis_tvalid && s_axis_tready;
  assign frame_last_beat = (x_reg == X_LAST) && (y_reg == Y_LAST);
  // In DRAIN nothing is pushed, so the pop that empties the buffer is the
  // final pixel of the frame.
  assign drain_done      = (state_reg == DRAIN) && m_axis_tvalid && m_axis_tready
                           && (level == 2'd1);
  assign restart         = frame_sync && ((state_reg != IDLE) || enable);

  // Tags are fixed at acceptance so a later resync cannot retag buffered beats.
  assign in_tag.tuser = (x_reg == '0) && (y_reg == '0);
  assign in_tag.tlast = (x_reg == X_LAST);
  assign in_payload   = {s_axis_tdata, in_tag};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable && frame_sync) state_next = ACTIVE;
      ACTIVE:  if (frame_sync) state_next = ACTIVE;
               else if (accept && frame_last_beat) state_next = DRAIN;
      DRAIN:   if (frame_sync) state_next = ACTIVE;
               else if (drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A beat accepted together with frame_sync already took the pre-sync tags
  // above; the counters then clear instead of advancing.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      x_reg <= '0;
      y_reg <= '0;
      b_reg <= '0;
    end else if (restart) begin
      x_reg <= '0;
      y_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      if (x_reg == X_LAST) begin
        x_reg <= '0;
        y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
      b_reg <= (s_axis_tlast || (b_reg == B_LAST)) ? '0 : b_reg + 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      frame_done_reg <= 1'b0;
      burst_err_reg  <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      frame_done_reg <= drain_done;
      burst_err_reg  <= accept && (s_axis_tlast != (b_reg == B_LAST));
      sync_err_reg   <= frame_sync && (state_reg != IDLE)
                        && ((x_reg != '0) || (y_reg != '0));
    end
  end

  axis_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .axi_clk   (axi_clk),
    .axi_rstn  (axi_rstn),
    .accept_en (state_next == ACTIVE),
    .s_data    (in_payload),
    .s_valid   (s_axis_tvalid),
    .s_ready   (s_axis_tready),
    .m_data    (out_payload),
    .m_valid   (m_axis_tvalid),
    .m_ready   (m_axis_tready),
    .level     (level)
  );

  assign out_tag      = beat_tag_t'(out_payload[TAG_WIDTH-1:0]);
  assign m_axis_tdata = out_payload[PAYLOAD_W-1:TAG_WIDTH];
  assign m_axis_tuser = out_tag.tuser;
  assign m_axis_tlast = out_tag.tlast;

  assign busy       = (state_reg != IDLE);
  assign frame_done = frame_done_reg;
  assign burst_err  = burst_err_reg;
  assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_axis_line_framer.sv
// -----------------------------------------------------------------------------
// tb_axis_line_framer
// Self-checking bench for axis_line_framer with H_ACTIVE=8, V_ACTIVE=2,
// BURST_LEN=4. A frame-position model predicts tags, burst errors, sync errors
// and frame completion for every accepted beat; an output monitor compares the
// emitted stream against the predicted queue.
// -----------------------------------------------------------------------------
module tb_axis_line_framer;

  localparam int DW    = 16;
  localparam int H     = 8;
  localparam int V     = 2;
  localparam int BL    = 4;
  localparam int FRAME = H * V;

  logic          axi_clk = 1'b0;
  logic          axi_rstn = 1'b0;
  logic          enable = 1'b0;
  logic          frame_sync = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          busy, frame_done, burst_err, sync_err;

  axis_line_framer #(
    .DATA_WIDTH (DW),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .BURST_LEN  (BL)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_rstn      (axi_rstn),
    .enable        (enable),
    .frame_sync    (frame_sync),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .frame_done    (frame_done),
    .burst_err     (burst_err),
    .sync_err      (sync_err)
  );

  always #5 axi_clk = ~axi_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW+1:0] word;   // {tdata, tuser, tlast}
    bit            fin;    // last pixel of a completed frame
  } exp_t;

  exp_t exp_q[$];
  int   pos = 0;          // pixel index within the current frame
  int   bpos = 0;         // beat index within the current input burst
  bit   model_busy = 0;
  int   exp_done = 0, exp_berr = 0, exp_serr = 0;
  int   done_seen = 0, berr_seen = 0, serr_seen = 0;
  int   total_wait = 0;

  task automatic model_accept(input logic [DW-1:0] d, input logic l, output bit be);
    exp_t e;
    e.word = {d, (pos == 0), ((pos % H) == H - 1)};
    e.fin  = (pos == FRAME - 1);
    exp_q.push_back(e);
    be = (l != (bpos == BL - 1));
    if (be) exp_berr++;
    bpos = (l || bpos == BL - 1) ? 0 : bpos + 1;
    if (e.fin) exp_done++;
    pos = e.fin ? 0 : pos + 1;
  endtask

  // ---------------- output ready pattern ----------------
  int rdy_mode = 1;   // 0 hold low, 1 hold high, 2 toggle, 3 random
  always @(negedge axi_clk) begin
    case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      2:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- output monitor ----------------
  bit            prev_stall = 0;
  bit            done_due = 0;
  logic [DW+1:0] prev_word = '0;

  always begin
    logic [DW+1:0] got;
    exp_t e;
    @(negedge axi_clk);
    #1;
    got = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    if (axi_rstn) begin
      if (done_due) begin
        chk("frame_done_timing", 32'(frame_done), 32'd1);
        done_due = 0;
      end
      if (frame_done) done_seen++;
      if (burst_err)  berr_seen++;
      if (sync_err)   serr_seen++;
      if (prev_stall)
        chk("stall_hold", 32'({m_axis_tvalid, got}), 32'({1'b1, prev_word}));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 32'(got), 32'h3ffff);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 32'(got), 32'(e.word));
          if (e.fin) done_due = 1;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = got;
    end else begin
      prev_stall = 0;
      done_due   = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_beat(input logic [DW-1:0] d, input logic l, input int max_wait, output bit ok);
    int w = 0;
    bit be;
    ok = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!ok && w <= max_wait) begin
      if (s_axis_tready) ok = 1;
      @(negedge axi_clk);
      if (!ok) w++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    total_wait += w;
    if (ok) begin
      model_accept(d, l, be);
      chk("burst_err_pulse", 32'(burst_err), 32'(be));
    end
  endtask

  task automatic send_beats(input int first_idx, input int n, input int lres,
                            input bit rnd_data, input bit gaps);
    bit ok;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      int idx = first_idx + i;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge axi_clk);
      d = rnd_data ? DW'($urandom) : DW'(idx);
      push_beat(d, ((idx % BL) == lres), 200, ok);
      if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    end
  endtask

  task automatic pulse_sync();
    bit exp_se;
    exp_se = model_busy && (pos != 0);
    frame_sync = 1'b1;
    @(negedge axi_clk);
    frame_sync = 1'b0;
    if (enable || model_busy) begin
      pos = 0;
      bpos = 0;
      model_busy = 1;
    end
    if (exp_se) exp_serr++;
    chk("sync_err_pulse", 32'(sync_err), 32'(exp_se));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge axi_clk);
      n++;
    end
    chk("drain_to_idle", 32'(busy), 32'd0);
    repeat (2) @(negedge axi_clk);
    model_busy = 0;
  endtask

  task automatic check_counts(input string tag);
    $display("step %s: done=%0d berr=%0d serr=%0d queued=%0d", tag, done_seen, berr_seen, serr_seen, exp_q.size());
    chk({tag, "_frame_done_count"}, 32'(done_seen), 32'(exp_done));
    chk({tag, "_burst_err_count"},  32'(berr_seen), 32'(exp_berr));
    chk({tag, "_sync_err_count"},   32'(serr_seen), 32'(exp_serr));
    chk({tag, "_queue_empty"},      32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int acc;
    int idx;

    // Reset values
    repeat (3) @(negedge axi_clk);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tuser",  32'(m_axis_tuser),  32'd0);
    chk("rst_busy",   32'(busy),          32'd0);
    chk("rst_pulses", 32'({frame_done, burst_err, sync_err}), 32'd0);
    axi_rstn = 1'b1;
    @(negedge axi_clk);

    // Gating: frame_sync without enable is ignored
    enable = 1'b0;
    pulse_sync();
    repeat (3) @(negedge axi_clk);
    chk("gate_tready", 32'(s_axis_tready), 32'd0);
    chk("gate_busy",   32'(busy),          32'd0);

    // Frame pass-through, data 0..15, full throughput
    enable = 1'b1;
    rdy_mode = 1;
    pulse_sync();
    chk("start_busy", 32'(busy), 32'd1);
    total_wait = 0;
    push_beat(16'd0, 1'b0, 200, ok);
    chk("first_accept", 32'(ok), 32'd1);
    chk("latency_1", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tdata}), 32'({2'b11, 16'd0}));
    send_beats(1, FRAME - 1, BL - 1, 1'b0, 1'b0);
    chk("throughput_no_wait", 32'(total_wait), 32'd0);
    wait_idle();
    check_counts("passthru");

    // Backpressure: stall stops input after two beats, then toggling ready
    pulse_sync();
    rdy_mode = 0;
    acc = 0;
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      push_beat(DW'(idx), ((idx % BL) == BL - 1), 3, ok);
      if (ok) begin
        acc++;
        idx++;
      end
    end
    chk("stall_accept_count", 32'(acc), 32'd2);
    chk("stall_tready_low", 32'(s_axis_tready), 32'd0);
    rdy_mode = 2;
    send_beats(idx, FRAME - idx, BL - 1, 1'b0, 1'b0);
    wait_idle();
    check_counts("backpressure");

    // Bad burst: tlast on beats 2, 6, 10, 14
    rdy_mode = 1;
    pulse_sync();
    send_beats(0, FRAME, 2, 1'b1, 1'b0);
    wait_idle();
    check_counts("bad_burst");

    // Mid-frame resync after 5 beats, then a full frame
    rdy_mode = 3;
    pulse_sync();
    send_beats(0, 5, BL - 1, 1'b1, 1'b0);
    pulse_sync();
    send_beats(0, FRAME, BL - 1, 1'b1, 1'b0);
    wait_idle();
    check_counts("resync");

    // Random data, random input gaps and random output ready, two frames
    for (int f = 0; f < 2; f++) begin
      pulse_sync();
      send_beats(0, FRAME, BL - 1, 1'b1, 1'b1);
      wait_idle();
    end
    check_counts("random");

    // Reset mid-frame discards buffered beats
    rdy_mode = 0;
    pulse_sync();
    send_beats(0, 2, BL - 1, 1'b1, 1'b0);
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    axi_rstn = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_tready", 32'(s_axis_tready), 32'd0);
    chk("midrst_busy",   32'(busy),          32'd0);
    chk("midrst_tdata",  32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'd0);
    exp_q.delete();
    pos = 0;
    bpos = 0;
    model_busy = 0;
    @(negedge axi_clk);
    axi_rstn = 1'b1;
    rdy_mode = 1;
    @(negedge axi_clk);
    push_beat(DW'($urandom), 1'b0, 5, ok);
    chk("post_rst_ignored", 32'(ok), 32'd0);
    pulse_sync();
    send_beats(0, FRAME, BL - 1, 1'b1, 1'b1);
    wait_idle();
    check_counts("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
